// File: rtl/tpu_pkg.sv
// tpu_pkg: shared tpu constants and instruction-assembler state encoding
package tpu_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH = 8;
  localparam int INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;
  typedef enum logic {EXP_LO, EXP_HI} asm_state_e;
endpackage

// File: rtl/tpu_sync_fifo.sv
// tpu_sync_fifo: synchronous FIFO with count-derived full/empty and sync clear
module tpu_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_q];
  assign count = count_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  // storage needs no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/tpu_instr_feeder.sv
// tpu_instr_feeder: assembles host bytes into instructions and issues one per cycle
module tpu_instr_feeder
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  input  logic                         issue_en,
  input  logic                         flush,
  output logic [INSTR_WIDTH-1:0]       instruction,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         busy,
  output logic [7:0]                   issued_count
);
  asm_state_e state_q, state_d;
  logic [7:0] lo_q, lo_d, issued_q, issued_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d, head;
  logic full, empty, accept, push, pop;
  tpu_sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .push(push),
    .pop(pop),
    .din({byte_in, lo_q}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // handshake, assembler next state and issue selection; ready ignores issue_en so a full FIFO always blocks the high byte
  always_comb begin
    byte_ready = !rst && !flush && (state_q == EXP_LO || !full);
    accept = byte_valid && byte_ready;
    push = accept && state_q == EXP_HI;
    pop = issue_en && !empty && !flush;
    state_d = flush ? EXP_LO : accept ? (state_q == EXP_LO ? EXP_HI : EXP_LO) : state_q;
    lo_d = accept && state_q == EXP_LO ? byte_in : lo_q;
    instr_d = pop ? head : NOP_INSTR;
    issued_d = flush ? '0 : issued_q + {7'd0, pop && head != NOP_INSTR};
  end
  // state and issue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXP_LO;
      lo_q <= '0;
      instr_q <= NOP_INSTR;
      issued_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q <= lo_d;
      instr_q <= instr_d;
      issued_q <= issued_d;
    end
  end
  assign instruction = instr_q;
  assign issued_count = issued_q;
  assign busy = fifo_count != '0 || state_q == EXP_HI;
endmodule

// File: tb/tb_tpu_instr_feeder.sv
// tb_tpu_instr_feeder: directed vector table plus hand-written multi-cycle sequences
module tb_tpu_instr_feeder;
  logic clk = 1'b0;
  logic rst, byte_valid, issue_en, flush;
  logic [7:0] byte_in;
  logic byte_ready, busy;
  logic [15:0] instruction;
  logic [2:0] fifo_count;
  logic [7:0] issued_count;
  int nchk = 0;
  int nerr = 0;
  typedef struct {
    logic r, f, bv, ie;
    logic [7:0] b;
    logic rdy;
    logic [15:0] ins;
    int cnt;
    logic bsy;
    int iss;
  } vec_t;
  vec_t tv[$];
  logic [15:0] q[$];
  always #5 clk = ~clk;
  tpu_instr_feeder #(.FIFO_DEPTH(4), .INSTR_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .issue_en(issue_en),
    .flush(flush),
    .instruction(instruction),
    .fifo_count(fifo_count),
    .busy(busy),
    .issued_count(issued_count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void add(input logic r, f, bv, ie, input logic [7:0] b, input logic rdy,
                              input logic [15:0] ins, input int cnt, input logic bsy, input int iss);
    vec_t v;
    v.r = r; v.f = f; v.bv = bv; v.ie = ie; v.b = b;
    v.rdy = rdy; v.ins = ins; v.cnt = cnt; v.bsy = bsy; v.iss = iss;
    tv.push_back(v);
  endfunction
  task automatic drive(input logic r, f, bv, ie, input logic [7:0] b);
    rst = r; flush = f; byte_valid = bv; issue_en = ie; byte_in = b;
  endtask
  task automatic tick(input logic r, f, bv, ie, input logic [7:0] b);
    drive(r, f, bv, ie, b);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] w, input logic ie);
    drive(0, 0, 1, ie, w[7:0]);
    #1 chk("send_lo_ready", byte_ready, 1);
    @(posedge clk);
    #1 drive(0, 0, 1, ie, w[15:8]);
    #1 chk("send_hi_ready", byte_ready, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset, single instruction latency
    add(1,0,0,0,8'h00, 0,16'h0000,0,0,0);
    add(0,0,1,1,8'h34, 1,16'h0000,0,1,0);
    add(0,0,1,1,8'h12, 1,16'h0000,1,1,0);
    add(0,0,0,1,8'h00, 1,16'h1234,0,0,1);
    add(0,0,0,1,8'h00, 1,16'h0000,0,0,1);
    // fill to depth with issue held, fifth high byte blocked
    add(0,0,1,0,8'h01, 1,16'h0000,0,1,1);
    add(0,0,1,0,8'h01, 1,16'h0000,1,1,1);
    add(0,0,1,0,8'h02, 1,16'h0000,1,1,1);
    add(0,0,1,0,8'h02, 1,16'h0000,2,1,1);
    add(0,0,1,0,8'h03, 1,16'h0000,2,1,1);
    add(0,0,1,0,8'h03, 1,16'h0000,3,1,1);
    add(0,0,1,0,8'h04, 1,16'h0000,3,1,1);
    add(0,0,1,0,8'h04, 1,16'h0000,4,1,1);
    add(0,0,1,0,8'h05, 1,16'h0000,4,1,1);
    add(0,0,1,0,8'h05, 0,16'h0000,4,1,1);
    add(0,0,1,1,8'h05, 0,16'h0101,3,1,2);
    add(0,0,1,1,8'h05, 1,16'h0202,3,1,3);
    add(0,0,0,1,8'h00, 1,16'h0303,2,1,4);
    add(0,0,0,1,8'h00, 1,16'h0404,1,1,5);
    add(0,0,0,1,8'h00, 1,16'h0505,0,0,6);
    add(0,0,0,1,8'h00, 1,16'h0000,0,0,6);
    // flush discards a partial instruction
    add(0,0,1,1,8'hAA, 1,16'h0000,0,1,6);
    add(0,1,1,1,8'h55, 0,16'h0000,0,0,0);
    add(0,0,1,1,8'h78, 1,16'h0000,0,1,0);
    add(0,0,1,1,8'h56, 1,16'h0000,1,1,0);
    add(0,0,0,1,8'h00, 1,16'h5678,0,0,1);
    add(0,0,0,1,8'h00, 1,16'h0000,0,0,1);
    // flush beats a pending pop of buffered instructions
    add(0,0,1,0,8'h11, 1,16'h0000,0,1,1);
    add(0,0,1,0,8'h22, 1,16'h0000,1,1,1);
    add(0,0,1,0,8'h33, 1,16'h0000,1,1,1);
    add(0,0,1,0,8'h44, 1,16'h0000,2,1,1);
    add(0,1,1,1,8'h99, 0,16'h0000,0,0,0);
    add(0,0,0,1,8'h00, 1,16'h0000,0,0,0);
    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].f, tv[i].bv, tv[i].ie, tv[i].b);
      #1 chk($sformatf("v%0d_ready", i), byte_ready, tv[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_instr", i), instruction, tv[i].ins);
      chk($sformatf("v%0d_count", i), fifo_count, tv[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("v%0d_issued", i), issued_count, tv[i].iss);
    end
    // random byte_valid stream, scoreboard on issued instructions
    begin
      int sent = 0;
      int got = 0;
      logic bv, acc;
      logic [15:0] w;
      for (int c = 0; c < 2000 && got < 40; c++) begin
        bv = sent < 80 && $urandom_range(1, 0) == 1;
        w = {8'(8'h40 + sent / 2), 8'((sent / 2) * 7 + 1)};
        drive(0, 0, bv, 1, sent % 2 == 0 ? w[7:0] : w[15:8]);
        #1 acc = bv && byte_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          if (sent % 2 == 1) q.push_back(w);
          sent++;
        end
        if (instruction != 16'h0000) begin
          if (q.size() == 0) chk("stream_extra", instruction, 0);
          else chk("stream_order", instruction, q.pop_front());
          got++;
        end
        chk("stream_count_le4", fifo_count <= 3'd4, 1);
      end
      chk("stream_received", got, 40);
      chk("stream_leftover", q.size(), 0);
    end
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    // reset with instructions buffered
    tick(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) send(16'h0101 + 16'(k), 1);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    chk("pre_rst_issued", issued_count, 7);
    for (int k = 0; k < 3; k++) send(16'hBEE0 + 16'(k), 0);
    chk("pre_rst_count", fifo_count, 3);
    tick(1, 0, 0, 1, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 1, 0);
      chk("post_rst_no_stale", instruction, 0);
    end
    // 256 non-NOP issues wrap the counter, a NOP does not count
    for (int k = 0; k < 256; k++) send(16'(k + 1), 1);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    chk("wrap_issued", issued_count, 0);
    send(16'h0000, 1);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    chk("nop_issued", issued_count, 0);
    chk("nop_count", fifo_count, 0);
    send(16'h0F0F, 1);
    chk("after_nop_instr", instruction, 0);
    tick(0, 0, 0, 1, 0);
    chk("after_nop_issue", instruction, 16'h0F0F);
    chk("after_nop_issued", issued_count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
